// File: rtl/axi4_lite_regbank_slave_if.sv
// rtl/axi4_lite_regbank_slave_if.sv - AXI4-Lite bus bundle between a master and the register bank
interface axi4_lite_regbank_slave_if #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32
);
  logic [Addr_Width-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [Data_Width-1:0]   WDATA;
  logic [Data_Width/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [Addr_Width-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [Data_Width-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_regbank_slave.sv
// rtl/axi4_lite_regbank_slave.sv - AXI4-Lite responder for a bank of 32-bit registers
// Register 0 is a read-only ID word; all handshake outputs come straight from flops.
module axi4_lite_regbank_slave #(
  parameter int                    Addr_Width = 32,
  parameter int                    Data_Width = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [Data_Width-1:0] ID_VALUE   = 32'hA41C_0001
) (
  input logic                      clk,
  input logic                      rst,
  axi4_lite_regbank_slave_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = Data_Width / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {WR_IDLE, WR_HAVE_A, WR_HAVE_D, WR_COMMIT, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [Data_Width-1:0] regs [NUM_REGS];

  logic                  aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0]            b_resp, r_resp;
  logic [Data_Width-1:0] r_data;
  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_ok;
  logic [Data_Width-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic             aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0] aw_idx_in, ar_idx_in;
  logic             aw_ok_in, ar_in_range;
  logic             unused_addr_bits;

  assign aw_hs = bus.AWVALID && aw_ready;
  assign w_hs  = bus.WVALID && w_ready;
  assign ar_hs = bus.ARVALID && ar_ready;

  assign aw_idx_in   = bus.AWADDR[IDX_W+1:2];
  assign ar_idx_in   = bus.ARADDR[IDX_W+1:2];
  // A write is only honoured for an in-range, writable (non-ID) register.
  assign aw_ok_in    = (bus.AWADDR[Addr_Width-1:IDX_W+2] == '0) && (aw_idx_in != '0);
  assign ar_in_range = (bus.ARADDR[Addr_Width-1:IDX_W+2] == '0);
  assign unused_addr_bits = ^{bus.AWADDR[1:0], bus.ARADDR[1:0]};

  assign bus.AWREADY = aw_ready;
  assign bus.WREADY  = w_ready;
  assign bus.BVALID  = b_valid;
  assign bus.BRESP   = b_resp;
  assign bus.ARREADY = ar_ready;
  assign bus.RVALID  = r_valid;
  assign bus.RRESP   = r_resp;
  assign bus.RDATA   = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      aw_idx   <= '0;
      aw_ok    <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (aw_hs) begin
        aw_idx <= aw_idx_in;
        aw_ok  <= aw_ok_in;
      end
      if (w_hs) begin
        w_data <= bus.WDATA;
        w_strb <= bus.WSTRB;
      end
      unique case (wr_state)
        WR_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state <= WR_COMMIT;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
          end else if (aw_hs) begin
            wr_state <= WR_HAVE_A;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
          end else if (w_hs) begin
            wr_state <= WR_HAVE_D;
            aw_ready <= 1'b1;
            w_ready  <= 1'b0;
          end else begin
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
          end
        end
        WR_HAVE_A: begin
          if (w_hs) begin
            wr_state <= WR_COMMIT;
            w_ready  <= 1'b0;
          end
        end
        WR_HAVE_D: begin
          if (aw_hs) begin
            wr_state <= WR_COMMIT;
            aw_ready <= 1'b0;
          end
        end
        WR_COMMIT: begin
          if (aw_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
              if (w_strb[i]) regs[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
          end
          b_resp   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
          b_valid  <= 1'b1;
          wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.BREADY) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Reads sample the bank before any same-edge commit lands, so they see the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= RESP_OKAY;
      r_data   <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            rd_state <= RD_RESP;
            if (!ar_in_range) begin
              r_data <= '0;
              r_resp <= RESP_SLVERR;
            end else begin
              r_data <= (ar_idx_in == '0) ? ID_VALUE : regs[ar_idx_in];
              r_resp <= RESP_OKAY;
            end
          end else begin
            ar_ready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (bus.RREADY) begin
            r_valid  <= 1'b0;
            ar_ready <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_regbank_slave.sv
// tb/tb_axi4_lite_regbank_slave.sv - scoreboard bench for axi4_lite_regbank_slave
module tb_axi4_lite_regbank_slave;
  localparam int          NUM_REGS = 16;
  localparam logic [31:0] ID_VALUE = 32'hA41C_0001;
  localparam logic [31:0] ADDR_LIM = 32'(NUM_REGS * 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_regbank_slave_if #(.Addr_Width(32), .Data_Width(32)) bus ();

  axi4_lite_regbank_slave #(
    .Addr_Width(32),
    .Data_Width(32),
    .NUM_REGS  (NUM_REGS),
    .ID_VALUE  (ID_VALUE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [NUM_REGS];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];
  logic [1:0]  mon_b;
  logic [33:0] mon_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
  endtask

  function automatic logic [1:0] model_wresp(input logic [31:0] addr);
    if (addr >= ADDR_LIM || addr < 32'd4) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    if (model_wresp(addr) != 2'b00) return;
    idx = int'(addr >> 2);
    for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    int idx;
    if (addr >= ADDR_LIM) return {2'b10, 32'h0};
    idx = int'(addr >> 2);
    return {2'b00, (idx == 0) ? ID_VALUE : model[idx]};
  endfunction

  // Scoreboard monitor: compares every completed B and R handshake against the queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.BVALID && bus.BREADY) begin
      if (exp_b_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_bresp: got %h expected no response", bus.BRESP);
      end else begin
        mon_b = exp_b_q.pop_front();
        check("bresp", 32'(bus.BRESP), 32'(mon_b));
      end
    end
    if (!rst && bus.RVALID && bus.RREADY) begin
      if (exp_r_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rdata: got %h expected no response", bus.RDATA);
      end else begin
        mon_r = exp_r_q.pop_front();
        check("rdata", bus.RDATA, mon_r[31:0]);
        check("rresp", 32'(bus.RRESP), 32'(mon_r[33:32]));
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int         cyc;
    bit         aw_done, w_done, aw_fire, w_fire;
    logic [1:0] first_resp;
    exp_b_q.push_back(model_wresp(addr));
    model_write(addr, data, strb);
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done)) begin
      if (!aw_done && cyc >= aw_dly) begin bus.AWADDR = addr; bus.AWVALID = 1'b1; end
      if (!w_done && cyc >= w_dly) begin bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1; end
      @(negedge clk);
      if (w_done && !aw_done) check("wready_while_have_d", 32'(bus.WREADY), 32'd0);
      if (aw_done && !w_done) check("awready_while_have_a", 32'(bus.AWREADY), 32'd0);
      aw_fire = bus.AWVALID && bus.AWREADY;
      w_fire  = bus.WVALID && bus.WREADY;
      @(posedge clk); #1;
      if (aw_fire) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1;  bus.WVALID = 1'b0; end
      cyc++;
      if (cyc > 200) begin
        check("write_handshake_timeout", 32'd1, 32'd0);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check("bvalid_during_commit", 32'(bus.BVALID), 32'd0);
    @(negedge clk);
    check("bvalid_latency", 32'(bus.BVALID), 32'd1);
    first_resp = bus.BRESP;
    for (int k = 0; k < b_dly; k++) begin
      @(negedge clk);
      check("bvalid_held", 32'(bus.BVALID), 32'd1);
      check("bresp_stable", 32'(bus.BRESP), 32'(first_resp));
      check("awready_in_resp", 32'(bus.AWREADY), 32'd0);
      check("wready_in_resp", 32'(bus.WREADY), 32'd0);
    end
    @(posedge clk); #1 bus.BREADY = 1'b1;
    @(posedge clk); #1 bus.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int          cyc;
    bit          fire;
    logic [31:0] first_data;
    logic [1:0]  first_resp;
    exp_r_q.push_back(model_read(addr));
    repeat (ar_dly) begin @(posedge clk); #1; end
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    cyc = 0; fire = 0;
    while (!fire) begin
      @(negedge clk);
      fire = bus.ARVALID && bus.ARREADY;
      @(posedge clk); #1;
      cyc++;
      if (!fire && cyc > 200) begin
        check("read_handshake_timeout", 32'd1, 32'd0);
        bus.ARVALID = 1'b0;
        return;
      end
    end
    bus.ARVALID = 1'b0;
    @(negedge clk);
    check("rvalid_latency", 32'(bus.RVALID), 32'd1);
    first_data = bus.RDATA;
    first_resp = bus.RRESP;
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      check("rvalid_held", 32'(bus.RVALID), 32'd1);
      check("rdata_stable", bus.RDATA, first_data);
      check("rresp_stable", 32'(bus.RRESP), 32'(first_resp));
      check("arready_in_resp", 32'(bus.ARREADY), 32'd0);
    end
    @(posedge clk); #1 bus.RREADY = 1'b1;
    @(posedge clk); #1 bus.RREADY = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_awready", 32'(bus.AWREADY), 32'd0);
    check("reset_wready", 32'(bus.WREADY), 32'd0);
    check("reset_arready", 32'(bus.ARREADY), 32'd0);
    check("reset_bvalid", 32'(bus.BVALID), 32'd0);
    check("reset_rvalid", 32'(bus.RVALID), 32'd0);
    check("reset_bresp", 32'(bus.BRESP), 32'd0);
    check("reset_rresp", 32'(bus.RRESP), 32'd0);
    check("reset_rdata", bus.RDATA, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_awready", 32'(bus.AWREADY), 32'd1);
    check("post_reset_wready", 32'(bus.WREADY), 32'd1);
    check("post_reset_arready", 32'(bus.ARREADY), 32'd1);
    @(posedge clk); #1;

    do_read(32'h0, 0, 0);
    do_read(32'h4, 1, 0);
    do_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h8, 0, 0);
    do_write(32'h8, 32'h1234_5678, 4'b0101, 3, 0, 0);
    do_read(32'h8, 0, 0);
    do_write(32'h40, 32'h5555_AAAA, 4'hF, 0, 1, 0);
    do_write(32'h0, 32'h5555_AAAA, 4'hF, 1, 0, 0);
    do_read(32'h0, 0, 0);
    do_read(32'h44, 0, 0);
    do_write(32'h14, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    do_read(32'h14, 0, 0);

    fork
      do_write(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
      do_read(32'h8, 0, 5);
    join

    bus.AWADDR = 32'hC; bus.AWVALID = 1'b1;
    @(negedge clk);
    check("abort_awready_idle", 32'(bus.AWREADY), 32'd1);
    @(posedge clk); #1 bus.AWVALID = 1'b0;
    @(negedge clk);
    check("abort_awready_have_a", 32'(bus.AWREADY), 32'd0);
    check("abort_wready_have_a", 32'(bus.WREADY), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_bvalid", 32'(bus.BVALID), 32'd0);
    end
    check("abort_awready_back", 32'(bus.AWREADY), 32'd1);
    check("abort_wready_back", 32'(bus.WREADY), 32'd1);
    check("abort_arready_back", 32'(bus.ARREADY), 32'd1);
    @(posedge clk); #1;
    do_read(32'hC, 0, 0);
    do_read(32'h8, 0, 0);

    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] wa, ra, wd;
      logic [3:0]  ws;
      wa = 32'(($urandom_range(0, NUM_REGS + 1) << 2) | $urandom_range(0, 3));
      ra = 32'(($urandom_range(0, NUM_REGS + 1) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) wa = wa | 32'h0000_1000;
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h8000_0000;
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 2));
      if (kind == 2 && (ra >> 2) == (wa >> 2)) ra = ra ^ 32'h4;
      case (kind)
        0: do_write(wa, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        1: do_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        default: fork
          do_write(wa, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
          do_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        join
      endcase
    end

    repeat (5) @(posedge clk);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
    check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_lite_regbank_slave.md
# axi4_lite_regbank_slave

AXI4-Lite responder that terminates master transactions into a bank of `NUM_REGS` 32-bit memory-mapped registers. It accepts write address and write data on independent channels in any order, applies byte strobes, and returns OKAY/SLVERR responses. Reads are served from the same bank. It sits behind `axi4_lite_master` as the register endpoint for control/status logic.

## Interface
- `Addr_Width`, 32, AXI address width
- `Data_Width`, 32, AXI data width (fixed 32; `WSTRB` is `Data_Width/8`)
- `NUM_REGS`, 16, number of 32-bit registers; power of two, 2..256
- `ID_VALUE`, 32'hA41C_0001, constant returned by register 0
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset: one clock, synchronous, active-high
- `AWADDR`  in  Addr_Width  write address
- `AWVALID` / `AWREADY`  in / out  1  write-address handshake
- `WDATA`  in  Data_Width  write data
- `WSTRB`  in  Data_Width/8  byte-lane enables
- `WVALID` / `WREADY`  in / out  1  write-data handshake
- `BRESP`  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- `BVALID` / `BREADY`  out / in  1  write-response handshake
- `ARADDR`  in  Addr_Width  read address
- `ARVALID` / `ARREADY`  in / out  1  read-address handshake
- `RDATA`  out  Data_Width  read data
- `RRESP`  out  2  read response, same encoding as `BRESP`
- `RVALID` / `RREADY`  out / in  1  read-data handshake

## Operation
- Decode: word index = `addr[log2(NUM_REGS)+1:2]`; `addr[1:0]` ignored; in range iff `addr < NUM_REGS*4`.
- Register 0: read-only, always `ID_VALUE`. Registers 1..NUM_REGS-1: read/write, reset to 0.
- Write FSM states: WR_IDLE, WR_HAVE_A, WR_HAVE_D, WR_COMMIT, WR_RESP.
  - WR_IDLE: `AWREADY=WREADY=1`. AW only → WR_HAVE_A; W only → WR_HAVE_D; both in same cycle → WR_COMMIT. Address, data, and strobe are latched on their handshakes.
  - WR_HAVE_A: `AWREADY=0`, `WREADY=1`. W handshake → WR_COMMIT. WR_HAVE_D is symmetric.
  - WR_COMMIT: both readies 0. The register is updated for each lane with `WSTRB[i]=1`; lanes with `WSTRB[i]=0` are unchanged. `BRESP` is latched → WR_RESP.
  - `BRESP=SLVERR` if the address is out of range or index is 0; no register changes in that case. `WSTRB=0` to a valid register gives OKAY with no change.
  - WR_RESP: `BVALID=1`, `BRESP` stable; `BREADY=1` → WR_IDLE.
- Read FSM states: RD_IDLE, RD_RESP.
  - RD_IDLE: `ARREADY=1`. On handshake, `RDATA` and `RRESP` are latched → RD_RESP. Out-of-range reads return `RDATA=0`, `RRESP=SLVERR`.
  - RD_RESP: `ARREADY=0`, `RVALID=1`, `RDATA`/`RRESP` stable; `RREADY=1` → RD_IDLE.
- Read and write FSMs are independent and may be active in the same cycle.

## Timing
- Reset: both FSMs go to idle and registers 1..N-1 are cleared. `BVALID=RVALID=0`, `BRESP=RRESP=2'b00`, `RDATA=0`. While `rst=1`, `AWREADY=WREADY=ARREADY=0`; they rise in the first cycle after `rst` deasserts.
- Readies and valids are decoded from registered state only; there is no combinational VALID→READY path.
- Write latency: if the last of AW/W handshakes at edge N, the register updates and `BVALID` rises at edge N+1.
- Read latency: if AR handshakes at edge N, `RVALID`/`RDATA` are valid after edge N.
- Throughput:
  - Write: 3 cycles per write when `BREADY` is held high.
  - Read: 2 cycles per read when `RREADY` is held high.
- Read/write collision: if a read is sampled at the same edge as a WR_COMMIT to the same register, it returns the pre-write value.
- Backpressure: `BVALID`/`RVALID` are held indefinitely with payload stable until their ready input is high. No new AW/W is accepted while in WR_RESP, and no new AR while in RD_RESP.
- `rst` mid-transaction aborts it: the pending write is dropped (register unchanged), and pending responses are cleared in the next cycle.

## Test plan
- Reset then read 0x0 → `RDATA=32'hA41C_0001`, `RRESP=00`. Read 0x4 → `RDATA=0`, OKAY.
- AW (0x8) and W (0xDEADBEEF, strobe 4'hF) in the same cycle → `BVALID` one cycle later with OKAY; read 0x8 → 0xDEADBEEF.
- W first (0x1234_5678, strobe 4'b0101), AW (0x8) three cycles later, prior contents 0xDEADBEEF → read returns 0xDE34BE78. Check `WREADY=0` while waiting for AW.
- Write 0x40 (out of range, NUM_REGS=16) and write 0x0 → `BRESP=10` for both; register 0 still reads ID. Read 0x44 → `RDATA=0`, `RRESP=10`.
- Hold `BREADY=0` and `RREADY=0` for 5 cycles → `BVALID`/`RVALID` and payloads stay stable; `AWREADY=WREADY=ARREADY=0` throughout.
- Assert `rst` in WR_HAVE_A after AW to 0xC → register 0xC stays 0 and `BVALID` never rises; readies return after reset.
